// File: rtl/mult8_pkg.sv
// rtl/mult8_pkg.sv - shared encodings for the 8-bit multiplier control unit
//
// Purpose: the FSM state encoding and the SELROM / SELSOMA select codes used
// by uc_multiplier8bits when driving the FD_multiplier8bits datapath.
// Ports: none (package).

package mult8_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    LOAD_XY     = 4'd1,
    LOAD_DE0    = 4'd2,
    SEL_A       = 4'd3,
    LOAD_A      = 4'd4,
    SEL_B       = 4'd5,
    LOAD_B      = 4'd6,
    SEL_DE1     = 4'd7,
    LOAD_DE1    = 4'd8,
    SUM1        = 4'd9,
    SUM2        = 4'd10,
    SUM3        = 4'd11,
    WAIT_PRONTO = 4'd12,
    DONE_S      = 4'd13
  } state_e;

  // SELROM codes
  localparam logic [1:0] ROM_NONE = 2'd0;
  localparam logic [1:0] ROM_A    = 2'd1;
  localparam logic [1:0] ROM_B    = 2'd2;
  localparam logic [1:0] ROM_DE1  = 2'd3;

  // SELSOMA codes
  localparam logic [1:0] SOMA_NONE = 2'd0;
  localparam logic [1:0] SOMA_1    = 2'd1;
  localparam logic [1:0] SOMA_2    = 2'd2;
  localparam logic [1:0] SOMA_3    = 2'd3;

endpackage

// File: rtl/uc_wait_counter.sv
// rtl/uc_wait_counter.sv - loadable down-counter with zero flag
//
// Purpose: times the hold states of the multiplier control unit. Loading
// N-1 on state entry makes the zero flag rise in the N-th cycle of the state.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   load     in   load load_val this cycle (has priority over decrement)
//   load_val in   WIDTH-bit value to load
//   zero     out  count is 0

module uc_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/uc_multiplier8bits.sv
// rtl/uc_multiplier8bits.sv - control unit sequencing the 8-bit multiplier datapath
//
// Purpose: Moore FSM that turns a START request into the LD_XY, LD_DE0,
// SELROM/LD_A, SELROM/LD_B, SELROM/LD_DE1, SELSOMA 1..3 sequence, waits for
// PRONTO and pulses DONE for one cycle.
// Optional feature: define MULT_TIMEOUT_EN to add a PRONTO timeout of TIMEOUT
// cycles that pulses ERR and returns to IDLE; without it ERR is tied to 0
// and the TIMEOUT parameter does not exist.
// Ports:
//   CLK      in   clock, rising edge
//   RESET_N  in   asynchronous active-low reset
//   START    in   multiply request, sampled only in IDLE
//   PRONTO   in   datapath result-valid, looked at only in WAIT_PRONTO
//   BUSY     out  high outside IDLE
//   DONE     out  one-cycle pulse, result valid
//   ERR      out  one-cycle pulse on PRONTO timeout
//   LD_XY, LD_DE0, LD_A, LD_B, LD_DE1  out  datapath register loads
//   SELROM   out  ROM select
//   SELSOMA  out  adder-input select

module uc_multiplier8bits
  import mult8_pkg::*;
#(
  parameter int ROM_WAIT = 1,
  parameter int SUM_WAIT = 1
`ifdef MULT_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 64
`endif
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic       PRONTO,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       LD_XY,
  output logic       LD_DE0,
  output logic       LD_A,
  output logic       LD_B,
  output logic       LD_DE1,
  output logic [1:0] SELROM,
  output logic [1:0] SELSOMA
);

  // The shared counter only grows beyond 4 bits when it also times PRONTO.
`ifdef MULT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
`else
  localparam int CNT_W = 4;
`endif

  state_e             state_q;
  state_e             state_d;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_zero;

`ifdef MULT_TIMEOUT_EN
  logic err_q;
  logic err_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef MULT_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE:        if (START) state_d = LOAD_XY;
      LOAD_XY:     state_d = LOAD_DE0;
      LOAD_DE0:    state_d = SEL_A;
      SEL_A:       if (cnt_zero) state_d = LOAD_A;
      LOAD_A:      state_d = SEL_B;
      SEL_B:       if (cnt_zero) state_d = LOAD_B;
      LOAD_B:      state_d = SEL_DE1;
      SEL_DE1:     if (cnt_zero) state_d = LOAD_DE1;
      LOAD_DE1:    state_d = SUM1;
      SUM1:        if (cnt_zero) state_d = SUM2;
      SUM2:        if (cnt_zero) state_d = SUM3;
      SUM3:        if (cnt_zero) state_d = WAIT_PRONTO;
      WAIT_PRONTO: begin
        if (PRONTO) begin
          state_d = DONE_S;
`ifdef MULT_TIMEOUT_EN
        end else if (cnt_zero) begin
          state_d = IDLE;
          err_d   = 1'b1;
`endif
        end
      end
      DONE_S:      state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Reload on every state change with the hold length of the state entered.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    case (state_d)
      SEL_A, SEL_B, SEL_DE1: cnt_load_val = CNT_W'(ROM_WAIT - 1);
      SUM1, SUM2, SUM3:      cnt_load_val = CNT_W'(SUM_WAIT - 1);
`ifdef MULT_TIMEOUT_EN
      WAIT_PRONTO:           cnt_load_val = CNT_W'(TIMEOUT - 1);
`endif
      default:               cnt_load_val = '0;
    endcase
  end

  uc_wait_counter #(
    .WIDTH(CNT_W)
  ) u_wait_counter (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .zero    (cnt_zero)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MULT_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  // Moore decode from the registered state only.
  always_comb begin
    BUSY    = (state_q != IDLE);
    DONE    = 1'b0;
    LD_XY   = 1'b0;
    LD_DE0  = 1'b0;
    LD_A    = 1'b0;
    LD_B    = 1'b0;
    LD_DE1  = 1'b0;
    SELROM  = ROM_NONE;
    SELSOMA = SOMA_NONE;
    case (state_q)
      LOAD_XY:     LD_XY   = 1'b1;
      LOAD_DE0:    LD_DE0  = 1'b1;
      SEL_A:       SELROM  = ROM_A;
      LOAD_A:      LD_A    = 1'b1;
      SEL_B:       SELROM  = ROM_B;
      LOAD_B:      LD_B    = 1'b1;
      SEL_DE1:     SELROM  = ROM_DE1;
      LOAD_DE1:    LD_DE1  = 1'b1;
      SUM1:        SELSOMA = SOMA_1;
      SUM2:        SELSOMA = SOMA_2;
      SUM3:        SELSOMA = SOMA_3;
      WAIT_PRONTO: SELSOMA = SOMA_3;
      DONE_S:      DONE    = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_uc_multiplier8bits.sv
// tb/tb_uc_multiplier8bits.sv - directed self-checking bench for uc_multiplier8bits

module tb_uc_multiplier8bits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic pronto;

  logic       a_busy, a_done, a_err, a_ld_xy, a_ld_de0, a_ld_a, a_ld_b, a_ld_de1;
  logic [1:0] a_selrom, a_selsoma;
  logic       b_busy, b_done, b_err, b_ld_xy, b_ld_de0, b_ld_a, b_ld_b, b_ld_de1;
  logic [1:0] b_selrom, b_selsoma;

  // Default parameters
  uc_multiplier8bits u_dut_a (
    .CLK(clk), .RESET_N(rst_n), .START(start), .PRONTO(pronto),
    .BUSY(a_busy), .DONE(a_done), .ERR(a_err),
    .LD_XY(a_ld_xy), .LD_DE0(a_ld_de0), .LD_A(a_ld_a), .LD_B(a_ld_b), .LD_DE1(a_ld_de1),
    .SELROM(a_selrom), .SELSOMA(a_selsoma)
  );

  // Longer holds
  uc_multiplier8bits #(.ROM_WAIT(3), .SUM_WAIT(2)) u_dut_b (
    .CLK(clk), .RESET_N(rst_n), .START(start), .PRONTO(pronto),
    .BUSY(b_busy), .DONE(b_done), .ERR(b_err),
    .LD_XY(b_ld_xy), .LD_DE0(b_ld_de0), .LD_A(b_ld_a), .LD_B(b_ld_b), .LD_DE1(b_ld_de1),
    .SELROM(b_selrom), .SELSOMA(b_selsoma)
  );

  // {BUSY, DONE, ERR, LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, SELROM, SELSOMA}
  wire [11:0] a_vec = {a_busy, a_done, a_err, a_ld_xy, a_ld_de0, a_ld_a, a_ld_b, a_ld_de1,
                       a_selrom, a_selsoma};
  wire [11:0] b_vec = {b_busy, b_done, b_err, b_ld_xy, b_ld_de0, b_ld_a, b_ld_b, b_ld_de1,
                       b_selrom, b_selsoma};

  // Expected default-parameter control word in cycle k after START is sampled.
  logic [11:0] exp_seq [0:14] = '{
    12'h000,  // 0  IDLE
    12'h900,  // 1  LOAD_XY
    12'h880,  // 2  LOAD_DE0
    12'h804,  // 3  SEL_A   SELROM=1
    12'h840,  // 4  LOAD_A
    12'h808,  // 5  SEL_B   SELROM=2
    12'h820,  // 6  LOAD_B
    12'h80C,  // 7  SEL_DE1 SELROM=3
    12'h810,  // 8  LOAD_DE1
    12'h801,  // 9  SUM1
    12'h802,  // 10 SUM2
    12'h803,  // 11 SUM3
    12'h803,  // 12 WAIT_PRONTO
    12'hC00,  // 13 DONE_S
    12'h000   // 14 IDLE
  };

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // START is high for exactly one sampling edge; returns in cycle 1.
  task automatic issue();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  int b_done_cyc;
  int b_rom1, b_rom2, b_rom3, b_soma1, b_soma2;
  int a_dones, b_dones;
  int done_at [0:3];

  initial begin
    rst_n  = 1'b0;
    start  = 1'b1;
    pronto = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_outputs_a", a_vec, 12'h000);
    check("reset_outputs_b", b_vec, 12'h000);
    start = 1'b0;
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("idle_after_release", a_vec, 12'h000);
    next_cycle();

    // Nominal sequence, PRONTO already high
    b_done_cyc = 0;
    b_rom1 = 0; b_rom2 = 0; b_rom3 = 0; b_soma1 = 0; b_soma2 = 0;
    issue();
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k <= 14) check($sformatf("seq_c%0d", k), a_vec, exp_seq[k]);
      if (b_done && b_done_cyc == 0) b_done_cyc = k;
      if (b_selrom == 2'd1) b_rom1++;
      if (b_selrom == 2'd2) b_rom2++;
      if (b_selrom == 2'd3) b_rom3++;
      if (b_selsoma == 2'd1) b_soma1++;
      if (b_selsoma == 2'd2) b_soma2++;
      next_cycle();
    end
    check("waits_done_cycle", b_done_cyc, 22);
    check("waits_selrom1_len", b_rom1, 3);
    check("waits_selrom2_len", b_rom2, 3);
    check("waits_selrom3_len", b_rom3, 3);
    check("waits_selsoma1_len", b_soma1, 2);
    check("waits_selsoma2_len", b_soma2, 2);

    // PRONTO low: stays in WAIT_PRONTO indefinitely
    pronto = 1'b0;
    a_dones = 0;
    issue();
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (a_done) a_dones++;
      if (k == 12) check("wait_entry", a_vec, 12'h803);
      if (k == 29) check("wait_hold", a_vec, 12'h803);
      next_cycle();
    end
    check("no_done_without_pronto", a_dones, 0);
    pronto = 1'b1;
    next_cycle();
    @(negedge clk);
    check("done_after_pronto", a_vec, 12'hC00);
    next_cycle();
    @(negedge clk);
    check("idle_after_done", a_vec, 12'h000);
    repeat (3) next_cycle();

    // START during SUM2 and during DONE_S is ignored
    a_dones = 0;
    b_dones = 0;
    issue();
    for (int k = 1; k <= 40; k++) begin
      start = (k == 10 || k == 13);
      @(negedge clk);
      if (a_done) a_dones++;
      if (b_done) b_dones++;
      next_cycle();
    end
    start = 1'b0;
    check("ignored_start_dones_a", a_dones, 1);
    check("ignored_start_dones_b", b_dones, 1);
    repeat (5) next_cycle();

    // START held high: back-to-back operations
    a_dones = 0;
    for (int i = 0; i < 4; i++) done_at[i] = 0;
    start = 1'b1;
    next_cycle();
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (a_done) begin
        if (a_dones < 4) done_at[a_dones] = k;
        a_dones++;
      end
      next_cycle();
    end
    start = 1'b0;
    check("held_done_count", a_dones, 3);
    check("held_first_done", done_at[0], 13);
    check("held_spacing_1", done_at[1] - done_at[0], 14);
    check("held_spacing_2", done_at[2] - done_at[1], 14);
    repeat (30) next_cycle();

    // Reset during LOAD_B aborts with no DONE
    issue();
    repeat (5) next_cycle();
    #2;
    check("load_b_before_reset", a_vec, 12'h820);
    rst_n = 1'b0;
    #1;
    check("abort_outputs_a", a_vec, 12'h000);
    check("abort_outputs_b", b_vec, 12'h000);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    a_dones = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (a_done) a_dones++;
      next_cycle();
    end
    check("abort_no_done", a_dones, 0);

    // A later START completes normally
    done_at[0] = 0;
    issue();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (a_done && done_at[0] == 0) done_at[0] = k;
      next_cycle();
    end
    check("after_abort_done_cycle", done_at[0], 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
